dma_pcie_mdma_byp_in_drv: RTL and testbench

Master-side driver for the MDMA descriptor bypass-in channel (dsc/cidx/vld/rdy).
- Accepts 256-bit descriptors from user/loopback logic through an upstream valid/ready port.
- Buffers them in a small FIFO and presents them on the bypass-in master interface.
- Stamps each descriptor with a ring consumer index (cidx) that advances modulo the ring size.
- Sits between descriptor-producing user logic and the DMA bypass-in slave.

---
 rtl/dma_pcie_mdma_byp_in_drv.sv | 131 +++++++++++++
 tb/tb_dma_pcie_mdma_byp_in_drv.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_pcie_mdma_byp_in_drv.sv
// Bypass-in master driver: buffers upstream descriptors in a small FIFO and
// presents them to the MDMA bypass-in port stamped with a ring consumer index.
module dma_pcie_mdma_byp_in_drv #(
  parameter int DEPTH     = 4,
  parameter int RING_SZ   = 1024,
  parameter int CIDX_INIT = 0
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic [255:0]               in_dsc,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic [255:0]               byp_in_dsc,
  output logic [15:0]                byp_in_cidx,
  output logic                       byp_in_vld,
  input  logic                       byp_in_rdy,
  input  logic                       flush,
  input  logic                       cidx_ld,
  input  logic [15:0]                cidx_ld_val,
  output logic                       cidx_ld_err,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic [31:0]                sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // 17-bit ring bounds so that RING_SZ = 65536 compares and wraps correctly
  localparam logic [16:0] RING_LIM  = 17'(RING_SZ);
  localparam logic [16:0] RING_LAST = 17'(RING_SZ - 1);

  logic [255:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   cidx_q, cidx_d;
  logic [31:0]   sent_q, sent_d;
  logic          err_q, err_d;
  logic          rdy_en_q;
  logic          push_s, pop_s;
  logic [16:0]   ld_ext_s;
  logic [15:0]   ld_mod_s;

  assign byp_in_vld  = (cnt_q != CW'(0));
  assign in_rdy      = rdy_en_q && (cnt_q < CW'(DEPTH)) && !flush;
  assign push_s      = in_vld && in_rdy;
  assign pop_s       = byp_in_vld && byp_in_rdy;
  assign byp_in_dsc  = byp_in_vld ? mem_q[rd_ptr_q] : 256'd0;
  assign byp_in_cidx = cidx_q;
  assign cidx_ld_err = err_q;
  assign fifo_cnt    = cnt_q;
  assign sent_cnt    = sent_q;

  // Out-of-range load values are reduced by one ring length
  assign ld_ext_s = {1'b0, cidx_ld_val};
  assign ld_mod_s = (ld_ext_s >= RING_LIM) ? 16'(ld_ext_s - RING_LIM) : cidx_ld_val;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    cidx_d   = cidx_q;
    sent_d   = sent_q;
    err_d    = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // A pop always advances cidx; a load is only legal while nothing is presented
    if (pop_s) begin
      cidx_d = ({1'b0, cidx_q} == RING_LAST) ? 16'd0 : cidx_q + 16'd1;
      sent_d = sent_q + 32'd1;
    end else if (cidx_ld && !byp_in_vld) begin
      cidx_d = ld_mod_s;
    end else begin
      cidx_d = cidx_q;
    end

    if (cidx_ld && byp_in_vld) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cidx_q   <= 16'(CIDX_INIT);
      sent_q   <= 32'd0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cidx_q   <= cidx_d;
      sent_q   <= sent_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge axi_aclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_dsc;
    end
  end

endmodule

// File: tb/tb_dma_pcie_mdma_byp_in_drv.sv
// Directed bench: a default-ring instance plus a RING_SZ=4 instance for wrap checks.
module tb_dma_pcie_mdma_byp_in_drv;

  logic         clk;
  logic         rst_n;

  logic [255:0] a_in_dsc, a_byp_dsc;
  logic         a_in_vld, a_in_rdy, a_byp_vld, a_byp_rdy, a_flush, a_ld, a_ld_err;
  logic [15:0]  a_ld_val, a_cidx;
  logic [2:0]   a_cnt;
  logic [31:0]  a_sent;

  logic [255:0] b_in_dsc, b_byp_dsc;
  logic         b_in_vld, b_in_rdy, b_byp_vld, b_byp_rdy, b_flush, b_ld, b_ld_err;
  logic [15:0]  b_ld_val, b_cidx;
  logic [2:0]   b_cnt;
  logic [31:0]  b_sent;

  int checks;
  int errors;

  dma_pcie_mdma_byp_in_drv #(.DEPTH(4), .RING_SZ(1024), .CIDX_INIT(0)) u_dut_a (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .in_dsc(a_in_dsc), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
    .byp_in_dsc(a_byp_dsc), .byp_in_cidx(a_cidx), .byp_in_vld(a_byp_vld),
    .byp_in_rdy(a_byp_rdy), .flush(a_flush), .cidx_ld(a_ld), .cidx_ld_val(a_ld_val),
    .cidx_ld_err(a_ld_err), .fifo_cnt(a_cnt), .sent_cnt(a_sent)
  );

  dma_pcie_mdma_byp_in_drv #(.DEPTH(4), .RING_SZ(4), .CIDX_INIT(0)) u_dut_b (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .in_dsc(b_in_dsc), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .byp_in_dsc(b_byp_dsc), .byp_in_cidx(b_cidx), .byp_in_vld(b_byp_vld),
    .byp_in_rdy(b_byp_rdy), .flush(b_flush), .cidx_ld(b_ld), .cidx_ld_val(b_ld_val),
    .cidx_ld_err(b_ld_err), .fifo_cnt(b_cnt), .sent_cnt(b_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] dk(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {8{w}};
  endfunction

  initial begin
    logic [255:0] d0;
    checks = 0;
    errors = 0;
    d0 = {32{8'hA5}};
    rst_n = 1'b0;
    a_in_dsc = '0; a_in_vld = 1'b0; a_byp_rdy = 1'b0; a_flush = 1'b0; a_ld = 1'b0; a_ld_val = 16'd0;
    b_in_dsc = '0; b_in_vld = 1'b0; b_byp_rdy = 1'b0; b_flush = 1'b0; b_ld = 1'b0; b_ld_val = 16'd0;

    // reset state
    #12;
    check_val("rst_in_rdy", a_in_rdy, 1'b0);
    check_val("rst_vld", a_byp_vld, 1'b0);
    check_val("rst_dsc", a_byp_dsc, 256'd0);
    check_val("rst_cidx", a_cidx, 16'd0);
    check_val("rst_cnt", a_cnt, 3'd0);
    check_val("rst_sent", a_sent, 32'd0);
    check_val("rst_err", a_ld_err, 1'b0);
    rst_n = 1'b1;
    step();
    check_val("rel_in_rdy", a_in_rdy, 1'b1);

    // single push: presented one cycle later, never in the push cycle
    a_in_vld = 1'b1; a_in_dsc = d0;
    #1;
    check_val("nofall_vld", a_byp_vld, 1'b0);
    step();
    a_in_vld = 1'b0;
    check_val("d0_vld", a_byp_vld, 1'b1);
    check_val("d0_dsc", a_byp_dsc, d0);
    check_val("d0_cidx", a_cidx, 16'd0);
    check_val("d0_cnt", a_cnt, 3'd1);
    a_byp_rdy = 1'b1;
    step();
    a_byp_rdy = 1'b0;
    check_val("d0_pop_vld", a_byp_vld, 1'b0);
    check_val("d0_pop_sent", a_sent, 32'd1);
    check_val("d0_pop_cidx", a_cidx, 16'd1);

    // reload cidx to 0 while empty
    a_ld = 1'b1; a_ld_val = 16'd0;
    step();
    a_ld = 1'b0;
    check_val("ld0_cidx", a_cidx, 16'd0);
    check_val("ld0_err", a_ld_err, 1'b0);

    // fill to DEPTH with the sink stalled
    for (int i = 0; i < 4; i++) begin
      a_in_vld = 1'b1; a_in_dsc = dk(i);
      check_val("fill_in_rdy", a_in_rdy, 1'b1);
      step();
    end
    check_val("full_in_rdy", a_in_rdy, 1'b0);
    check_val("full_cnt", a_cnt, 3'd4);
    a_in_dsc = dk(4);
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("stall_dsc", a_byp_dsc, dk(0));
      check_val("stall_cidx", a_cidx, 16'd0);
      check_val("stall_cnt", a_cnt, 3'd4);
    end
    a_byp_rdy = 1'b1;
    check_val("drain0_dsc", a_byp_dsc, dk(0));
    step();
    check_val("drain1_dsc", a_byp_dsc, dk(1));
    check_val("drain1_cidx", a_cidx, 16'd1);
    check_val("drain1_in_rdy", a_in_rdy, 1'b1);
    check_val("drain1_cnt", a_cnt, 3'd3);
    step();
    a_in_vld = 1'b0;
    check_val("drain2_dsc", a_byp_dsc, dk(2));
    check_val("drain2_cidx", a_cidx, 16'd2);
    check_val("drain2_cnt", a_cnt, 3'd3);
    step();
    check_val("drain3_dsc", a_byp_dsc, dk(3));
    check_val("drain3_cidx", a_cidx, 16'd3);
    check_val("drain3_cnt", a_cnt, 3'd2);
    step();
    check_val("drain4_dsc", a_byp_dsc, dk(4));
    check_val("drain4_cidx", a_cidx, 16'd4);
    step();
    a_byp_rdy = 1'b0;
    check_val("drain_end_vld", a_byp_vld, 1'b0);
    check_val("drain_end_sent", a_sent, 32'd6);
    check_val("drain_end_cidx", a_cidx, 16'd5);

    // load coinciding with a push: the pushed descriptor carries the loaded cidx
    a_ld = 1'b1; a_ld_val = 16'h0010; a_in_vld = 1'b1; a_in_dsc = dk(5);
    step();
    a_ld = 1'b0; a_in_vld = 1'b0;
    check_val("ld10_cidx", a_cidx, 16'h0010);
    check_val("ld10_dsc", a_byp_dsc, dk(5));
    check_val("ld10_err", a_ld_err, 1'b0);
    a_ld = 1'b1; a_ld_val = 16'h0033;
    step();
    a_ld = 1'b0;
    check_val("ldbusy_err", a_ld_err, 1'b1);
    check_val("ldbusy_cidx", a_cidx, 16'h0010);
    step();
    check_val("ldbusy_err_pulse", a_ld_err, 1'b0);
    a_byp_rdy = 1'b1;
    step();
    a_byp_rdy = 1'b0;
    check_val("pop5_cidx", a_cidx, 16'h0011);
    check_val("pop5_sent", a_sent, 32'd7);

    // out-of-range load is reduced by RING_SZ
    a_ld = 1'b1; a_ld_val = 16'd1030;
    step();
    a_ld = 1'b0;
    check_val("ldmod_cidx", a_cidx, 16'd6);

    // flush with 3 buffered and a push offered in the same cycle
    for (int i = 10; i < 13; i++) begin
      a_in_vld = 1'b1; a_in_dsc = dk(i);
      step();
    end
    check_val("preflush_cnt", a_cnt, 3'd3);
    a_flush = 1'b1; a_in_dsc = dk(13);
    #1;
    check_val("flush_in_rdy", a_in_rdy, 1'b0);
    step();
    a_flush = 1'b0; a_in_vld = 1'b0;
    check_val("flush_vld", a_byp_vld, 1'b0);
    check_val("flush_cnt", a_cnt, 3'd0);
    check_val("flush_cidx", a_cidx, 16'd6);
    check_val("flush_sent", a_sent, 32'd7);
    step();
    check_val("flush_drop_vld", a_byp_vld, 1'b0);

    // reset mid-stall with 2 buffered
    for (int i = 20; i < 22; i++) begin
      a_in_vld = 1'b1; a_in_dsc = dk(i);
      step();
    end
    a_in_vld = 1'b0;
    check_val("prerst_cnt", a_cnt, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_vld", a_byp_vld, 1'b0);
    check_val("arst_dsc", a_byp_dsc, 256'd0);
    check_val("arst_in_rdy", a_in_rdy, 1'b0);
    #3;
    rst_n = 1'b1;
    step();
    check_val("postrst_cidx", a_cidx, 16'd0);
    check_val("postrst_sent", a_sent, 32'd0);
    check_val("postrst_cnt", a_cnt, 3'd0);
    check_val("postrst_in_rdy", a_in_rdy, 1'b1);

    // RING_SZ=4: six back-to-back descriptors, cidx wraps 0,1,2,3,0,1
    b_byp_rdy = 1'b1; b_in_vld = 1'b1; b_in_dsc = dk(30);
    step();
    for (int i = 0; i < 6; i++) begin
      check_val("ring_vld", b_byp_vld, 1'b1);
      check_val("ring_dsc", b_byp_dsc, dk(30 + i));
      check_val("ring_cidx", b_cidx, 16'(i % 4));
      b_in_dsc = dk(31 + i);
      b_in_vld = (i < 5);
      step();
    end
    b_byp_rdy = 1'b0;
    check_val("ring_sent", b_sent, 32'd6);
    check_val("ring_end_vld", b_byp_vld, 1'b0);
    check_val("ring_end_cidx", b_cidx, 16'd2);
    b_ld = 1'b1; b_ld_val = 16'd6;
    step();
    b_ld = 1'b0;
    check_val("ring_ldmod_cidx", b_cidx, 16'd2);
    b_ld = 1'b1; b_ld_val = 16'd3;
    step();
    b_ld = 1'b0;
    check_val("ring_ld3_cidx", b_cidx, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
